// File: rtl/kbd_pkg.sv
// Shared keypad types: key count, scanner FSM states and a one-hot test helper.
package kbd_pkg;

    localparam int N_KEYS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [N_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus whole-vector debounce; a new key pattern is accepted only
// after DEBOUNCE_CYCLES consecutive equal synchronised samples.
module key_debounce
    import kbd_pkg::*;
#(
    parameter int NK              = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NK-1:0] keys_i,
    output logic [NK-1:0] stable_nxt_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NK-1:0] sync1_q, sync2_q, cand_q, stable_q, stable_d;
    logic [CW-1:0] cnt_q;

    // Exported as the next stable value so the scanner FSM acts on the same edge stable updates.
    always_comb begin
        stable_d = stable_q;
        if (sync2_q == cand_q && cnt_q == CNT_MAX)
            stable_d = cand_q;
    end

    assign stable_nxt_o = stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= keys_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_onehot_scanner.sv
// Keypad front end: debounced key vector -> single-key press FSM -> 1-deep valid/ready buffer
// holding a one-hot key code, with multi-key error pulse and sticky overrun flag.
module key_onehot_scanner
    import kbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] inKeys,
    input  logic              inReady,
    input  logic              inClrOvr,
    output logic [N_KEYS-1:0] outData,
    output logic              outValid,
    output logic              outHeld,
    output logic              outErrMulti,
    output logic              outOverrun
);

    logic [N_KEYS-1:0] stable;
    logic [N_KEYS-1:0] key_q, data_q;
    state_e            state_q;
    logic              valid_q, held_q, err_q, ovr_q;
    logic              load;

    key_debounce #(
        .NK              (N_KEYS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk          (clk),
        .rst          (rst),
        .keys_i       (inKeys),
        .stable_nxt_o (stable)
    );

    assign load = (state_q == IDLE) && is_onehot(stable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= HELD;
                        key_q   <= stable;
                        held_q  <= 1'b1;
                    end else if (stable != '0) begin
                        state_q <= LOCKOUT;
                        err_q   <= 1'b1;
                    end
                end
                HELD: begin
                    if (stable == '0) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end else if (stable != key_q) begin
                        state_q <= LOCKOUT;
                        held_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (stable == '0)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    held_q  <= 1'b0;
                end
            endcase

            // A load always wins over a consume; overrun only when the old code was never taken.
            if (load) begin
                data_q  <= stable;
                valid_q <= 1'b1;
            end else if (valid_q && inReady) begin
                valid_q <= 1'b0;
            end

            if (load && valid_q && !inReady)
                ovr_q <= 1'b1;
            else if (inClrOvr)
                ovr_q <= 1'b0;
        end
    end

    assign outData     = data_q;
    assign outValid    = valid_q;
    assign outHeld     = held_q;
    assign outErrMulti = err_q;
    assign outOverrun  = ovr_q;

endmodule

// File: tb/tb_key_onehot_scanner.sv
// Directed bench for key_onehot_scanner with DEBOUNCE_CYCLES=4; inputs change on the falling edge.
module tb_key_onehot_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inKeys;
    logic       inReady, inClrOvr;
    logic [7:0] outData;
    logic       outValid, outHeld, outErrMulti, outOverrun;

    int n_chk  = 0;
    int n_fail = 0;
    logic seen_v, seen_e;
    int   n_err;

    always #5 clk = ~clk;

    key_onehot_scanner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .inKeys      (inKeys),
        .inReady     (inReady),
        .inClrOvr    (inClrOvr),
        .outData     (outData),
        .outValid    (outValid),
        .outHeld     (outHeld),
        .outErrMulti (outErrMulti),
        .outOverrun  (outOverrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n rising edges, then park on the falling edge for sampling/driving
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic consume();
        inReady = 1'b1;
        step(1);
        inReady = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inKeys = 8'h10; inReady = 1'b0; inClrOvr = 1'b0;
        step(3);
        // 1 reset
        chk("rst_data",  outData,     8'h00);
        chk("rst_valid", outValid,    1'b0);
        chk("rst_held",  outHeld,     1'b0);
        chk("rst_err",   outErrMulti, 1'b0);
        chk("rst_ovr",   outOverrun,  1'b0);
        rst = 1'b0;
        step(6);
        chk("rst_press_early", outValid, 1'b0);
        step(1);
        chk("rst_press_valid", outValid, 1'b1);
        chk("rst_press_data",  outData,  8'h10);
        consume();
        inKeys = 8'h00;
        step(8);

        // 2 single press
        inKeys = 8'h04;
        step(6);
        chk("sp_early_valid", outValid, 1'b0);
        chk("sp_early_held",  outHeld,  1'b0);
        step(1);
        chk("sp_valid", outValid, 1'b1);
        chk("sp_data",  outData,  8'h04);
        chk("sp_held",  outHeld,  1'b1);
        consume();
        chk("sp_consumed", outValid, 1'b0);
        chk("sp_keep_data", outData, 8'h04);
        inKeys = 8'h00;
        step(6);
        chk("sp_rel_early", outHeld, 1'b1);
        step(1);
        chk("sp_rel_held", outHeld, 1'b0);

        // 3 bounce
        seen_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) inKeys = inKeys ^ 8'h01;
            step(1);
            seen_v |= outValid | outHeld;
        end
        inKeys = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1);
            seen_v |= outValid | outHeld;
        end
        chk("bounce_no_press", seen_v, 1'b0);

        // 4 multi-key
        inKeys = 8'h41;
        step(6);
        chk("mk_err_early", outErrMulti, 1'b0);
        step(1);
        chk("mk_err_pulse", outErrMulti, 1'b1);
        chk("mk_valid",     outValid,    1'b0);
        step(1);
        chk("mk_err_end", outErrMulti, 1'b0);
        inKeys = 8'h40;
        seen_v = 1'b0; seen_e = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen_v |= outValid | outHeld;
            seen_e |= outErrMulti;
        end
        chk("mk_locked_load", seen_v, 1'b0);
        chk("mk_locked_err",  seen_e, 1'b0);
        inKeys = 8'h00;
        step(8);
        inKeys = 8'h40;
        step(7);
        chk("mk_after_valid", outValid, 1'b1);
        chk("mk_after_data",  outData,  8'h40);
        consume();
        inKeys = 8'h00;
        step(8);

        // 5 overrun
        inKeys = 8'h02;
        step(7);
        chk("ov_first_data", outData,    8'h02);
        chk("ov_first_ovr",  outOverrun, 1'b0);
        inKeys = 8'h00;
        step(8);
        inKeys = 8'h80;
        step(7);
        chk("ov_data",  outData,    8'h80);
        chk("ov_valid", outValid,   1'b1);
        chk("ov_flag",  outOverrun, 1'b1);
        step(3);
        chk("ov_sticky", outOverrun, 1'b1);
        inClrOvr = 1'b1;
        step(1);
        inClrOvr = 1'b0;
        chk("ov_cleared", outOverrun, 1'b0);
        inKeys = 8'h00;
        step(8);
        inKeys = 8'h20;
        step(6);
        inReady = 1'b1;
        step(1);
        inReady = 1'b0;
        chk("lc_valid", outValid,   1'b1);
        chk("lc_data",  outData,    8'h20);
        chk("lc_ovr",   outOverrun, 1'b0);
        consume();
        chk("lc_consumed", outValid, 1'b0);
        inKeys = 8'h00;
        step(8);

        // 6 roll
        inKeys = 8'h08;
        step(7);
        chk("roll_data", outData, 8'h08);
        consume();
        inKeys = 8'h18;
        n_err = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (outErrMulti) n_err++;
        end
        chk("roll_err_count", n_err,   1);
        chk("roll_held",      outHeld, 1'b0);
        inKeys = 8'h10;
        seen_v = 1'b0; n_err = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen_v |= outValid | outHeld;
            if (outErrMulti) n_err++;
        end
        chk("roll_no_load", seen_v,  1'b0);
        chk("roll_no_err",  n_err,   0);
        chk("roll_data_kept", outData, 8'h08);
        inKeys = 8'h00;
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
